circuito_decodificador_funcionalidade: RTL and testbench

- Decodes the 3-bit functionality code CF back into the seven function-select lines A..G, which are one-hot or all zero.
- Sits at the receiving end of the functionality link. A debounce filter ensures that only a code held stable for STABLE_CYCLES enabled samples is committed.
- The committed selection is registered and held glitch-free until a new stable code commits. Downstream datapath blocks use FUNC to enable exactly one function.

---
 rtl/circuito_decodificador_funcionalidade_pkg.sv | 20 ++
 rtl/circuito_decodificador_funcionalidade_dec.sv | 24 ++
 rtl/circuito_decodificador_funcionalidade.sv | 122 ++++++++++++
 tb/tb_circuito_decodificador_funcionalidade.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/circuito_decodificador_funcionalidade_pkg.sv
// Shared constants for the functionality link: FSM state encoding and the
// seven function codes, also used by the encoder side.
package circuito_decodificador_funcionalidade_pkg;

  typedef logic [2:0] cod_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_FILTRANDO = 2'd1;
  localparam logic [1:0] ST_ATIVO     = 2'd2;

  localparam cod_t COD_NULO = 3'b000;
  localparam cod_t COD_A    = 3'b001;
  localparam cod_t COD_B    = 3'b010;
  localparam cod_t COD_C    = 3'b011;
  localparam cod_t COD_D    = 3'b100;
  localparam cod_t COD_E    = 3'b101;
  localparam cod_t COD_F    = 3'b110;
  localparam cod_t COD_G    = 3'b111;

endpackage

// File: rtl/circuito_decodificador_funcionalidade_dec.sv
// Combinational 3-to-7 decode of a functionality code into one-hot select
// lines {A..G}; the null code yields all zeros.
module decodificador_3x7_funcionalidade
  import circuito_decodificador_funcionalidade_pkg::*;
(
  input  logic [2:0] code,
  output logic [6:0] sel
);

  always_comb begin
    sel = 7'b0000000;
    case (code)
      COD_A:   sel = 7'b1000000;
      COD_B:   sel = 7'b0100000;
      COD_C:   sel = 7'b0010000;
      COD_D:   sel = 7'b0001000;
      COD_E:   sel = 7'b0000100;
      COD_F:   sel = 7'b0000010;
      COD_G:   sel = 7'b0000001;
      default: sel = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/circuito_decodificador_funcionalidade.sv
// Receiving end of the functionality link: debounces CF and commits a stable
// code to registered one-hot select lines FUNC.
//
//   state        | meaning
//   IDLE         | no filtering in progress; waiting for an enabled sample
//   FILTRANDO    | counting consecutive identical enabled samples of cand
//   ATIVO        | a code is committed; watching for a different code
module circuito_decodificador_funcionalidade
  import circuito_decodificador_funcionalidade_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] CF,
  output logic [6:0] FUNC,
  output logic       valid,
  output logic       nula,
  output logic       change
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C   = '0;
  localparam bit               DIRECT   = (STABLE_CYCLES == 1);

  logic [1:0]       state, state_nxt;
  logic [2:0]       cand, cand_nxt;
  logic [2:0]       cod_ativo;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             commit;
  logic [6:0]       sel;

  assign cnt_inc = cnt + ONE_C;

  // Decoding cand_nxt lets a single-sample filter commit on the capture edge.
  decodificador_3x7_funcionalidade u_dec (
    .code (cand_nxt),
    .sel  (sel)
  );

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          cand_nxt = CF;
          cnt_nxt  = ONE_C;
          if (DIRECT) begin
            commit    = 1'b1;
            state_nxt = ST_ATIVO;
          end else begin
            state_nxt = ST_FILTRANDO;
          end
        end
      end
      ST_FILTRANDO: begin
        if (!en) begin
          state_nxt = ST_IDLE;
          cand_nxt  = COD_NULO;
          cnt_nxt   = ZERO_C;
        end else if (CF != cand) begin
          cand_nxt = CF;
          cnt_nxt  = ONE_C;
        end else begin
          cnt_nxt = (cnt >= STABLE_C) ? STABLE_C : cnt_inc;
          if (cnt_inc == STABLE_C) begin
            commit    = 1'b1;
            state_nxt = ST_ATIVO;
          end
        end
      end
      ST_ATIVO: begin
        if (en && (CF != cod_ativo)) begin
          cand_nxt = CF;
          cnt_nxt  = ONE_C;
          if (DIRECT) begin
            commit = 1'b1;
          end else begin
            state_nxt = ST_FILTRANDO;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cand_nxt  = COD_NULO;
        cnt_nxt   = ZERO_C;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cand      <= COD_NULO;
      cnt       <= ZERO_C;
      cod_ativo <= COD_NULO;
      FUNC      <= 7'b0000000;
      valid     <= 1'b0;
      nula      <= 1'b0;
      change    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cand   <= cand_nxt;
      cnt    <= cnt_nxt;
      change <= 1'b0;
      if (commit) begin
        FUNC      <= sel;
        nula      <= (cand_nxt == COD_NULO);
        valid     <= 1'b1;
        change    <= !valid || (cand_nxt != cod_ativo);
        cod_ativo <= cand_nxt;
      end
    end
  end

endmodule

// File: tb/tb_circuito_decodificador_funcionalidade.sv
// Self-checking bench: a run-length reference model pushes expected outputs
// per edge into a scoreboard queue, popped and compared after each edge.
module tb_circuito_decodificador_funcionalidade;

  typedef struct packed {
    logic [6:0] func;
    logic       valid;
    logic       nula;
    logic       change;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] CF;
  logic [6:0] FUNC;
  logic       valid;
  logic       nula;
  logic       change;

  int n_checks = 0;
  int n_err    = 0;
  int n_pulses = 0;

  exp_t       sb[$];
  logic [6:0] map_tbl [8] = '{7'b0000000, 7'b1000000, 7'b0100000, 7'b0010000,
                              7'b0001000, 7'b0000100, 7'b0000010, 7'b0000001};

  // reference model state
  logic [2:0] m_run_code;
  int         m_run_len;
  logic [2:0] m_code;
  logic       m_valid;

  circuito_decodificador_funcionalidade #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .CF     (CF),
    .FUNC   (FUNC),
    .valid  (valid),
    .nula   (nula),
    .change (change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_run_code = 3'b000;
    m_run_len  = 0;
    m_code     = 3'b000;
    m_valid    = 1'b0;
    sb.delete();
  endtask

  task automatic step(input logic e, input logic [2:0] c);
    exp_t x;
    exp_t got;
    logic chg;
    en  = e;
    CF  = c;
    chg = 1'b0;
    if (!e) begin
      m_run_len = 0;
    end else begin
      if (m_run_len > 0 && c == m_run_code) begin
        if (m_run_len < 8) m_run_len++;
      end else begin
        m_run_code = c;
        m_run_len  = 1;
      end
      if (m_run_len == 4) begin
        chg     = !m_valid || (c != m_code);
        m_code  = c;
        m_valid = 1'b1;
      end
    end
    x.func   = m_valid ? map_tbl[m_code] : 7'b0000000;
    x.valid  = m_valid;
    x.nula   = m_valid && (m_code == 3'b000);
    x.change = chg;
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("sb_func", FUNC, got.func);
    chk("sb_valid", {6'b0, valid}, {6'b0, got.valid});
    chk("sb_nula", {6'b0, nula}, {6'b0, got.nula});
    chk("sb_change", {6'b0, change}, {6'b0, got.change});
    chk("onehot", {6'b0, ($countones(FUNC) <= 1)}, 7'd1);
    if (change) n_pulses++;
  endtask

  task automatic hold(input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) step(1'b1, c);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    CF  = 3'b000;
    model_reset();
    #12;
    chk("rst_func", FUNC, 7'b0000000);
    chk("rst_flags", {4'b0, valid, nula, change}, 7'b0000000);
    rst = 1'b0;

    // basic commit of F
    hold(3'b110, 3);
    chk("pre4_func", FUNC, 7'b0000000);
    chk("pre4_valid", {6'b0, valid}, 7'd0);
    step(1'b1, 3'b110);
    chk("e4_func", FUNC, 7'b0000010);
    chk("e4_flags", {4'b0, valid, nula, change}, 7'b0000101);
    step(1'b1, 3'b110);
    chk("e5_change", {6'b0, change}, 7'd0);

    // bounce back to F: no transition, no pulse
    n_pulses = 0;
    hold(3'b011, 2);
    hold(3'b110, 4);
    chk("bounce_func", FUNC, 7'b0000010);
    chk("bounce_pulses", 7'(n_pulses), 7'd0);
    hold(3'b011, 4);
    chk("c_func", FUNC, 7'b0010000);
    chk("c_pulses", 7'(n_pulses), 7'd1);

    // enable drop restarts counting
    hold(3'b001, 2);
    step(1'b0, 3'b001);
    step(1'b0, 3'b001);
    step(1'b0, 3'b001);
    hold(3'b001, 3);
    chk("drop_pre_func", FUNC, 7'b0010000);
    step(1'b1, 3'b001);
    chk("drop_func", FUNC, 7'b1000000);
    chk("drop_change", {6'b0, change}, 7'd1);

    // null code
    hold(3'b000, 4);
    chk("null_func", FUNC, 7'b0000000);
    chk("null_flags", {4'b0, valid, nula, change}, 7'b0000111);

    // async reset mid-filter at cnt=2
    hold(3'b101, 2);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_func", FUNC, 7'b0000000);
    chk("arst_flags", {4'b0, valid, nula, change}, 7'b0000000);
    #2;
    rst = 1'b0;
    model_reset();
    hold(3'b101, 3);
    chk("arst_restart_valid", {6'b0, valid}, 7'd0);
    step(1'b1, 3'b101);
    chk("arst_restart_func", FUNC, 7'b0000100);

    // sweep of all codes from a fresh reset
    step(1'b0, 3'b000);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    n_pulses = 0;
    for (int k = 0; k < 8; k++) begin
      hold(3'(k), 4);
      chk("sweep_func", FUNC, map_tbl[k]);
      chk("sweep_nula", {6'b0, nula}, {6'b0, (k == 0)});
    end
    chk("sweep_pulses", 7'(n_pulses), 7'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
